sram_boot_loader: RTL

Hardware program loader that replaces bench-driven SRAM programming. It accepts a valid/ready stream of instruction words and writes them into the instruction SRAM through the en/sel/we/addr/data port, starting at a programmable base address. An optional read-back checksum pass verifies the image. The CPU is held in reset until loading (and verification, if enabled) passes; the loader then drives the start PC.

---
 rtl/sram_boot_loader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sram_boot_loader.sv
// Streams instruction words into the instruction SRAM and can verify them by read-back checksum.
// The core is held in reset until the image is loaded and, if enabled, verified.
module sram_boot_loader #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  input  logic [ADDR_WIDTH-1:0] pc_start,
  input  logic                  verify_en,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  sram_en,
  output logic                  sram_sel,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  cpu_reset,
  output logic [ADDR_WIDTH-1:0] pc_init,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE, WRITE, VFY_RD, VFY_WAIT, CHECK, DONE, FAIL
  } state_t;

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] base_lat, pc_lat;
  logic [CNT_WIDTH-1:0]  cnt_lat, idx, rd_idx;
  logic                  verify_lat;
  logic [DATA_WIDTH-1:0] wr_sum, rd_sum;
  logic [RD_LAT-1:0]     rd_vld;
  logic                  start_ok;
  logic                  accept;

  assign start_ok  = start && (state == IDLE || state == DONE || state == FAIL);
  assign in_ready  = (state == WRITE) && (idx != cnt_lat);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);
  assign error     = (state == FAIL);
  assign cpu_reset = (state != DONE);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, FAIL: if (start) next_state = (word_count == '0) ? DONE : WRITE;
      WRITE:            if (idx == cnt_lat) next_state = verify_lat ? VFY_RD : DONE;
      VFY_RD:           if (rd_idx == cnt_lat) next_state = VFY_WAIT;
      VFY_WAIT:         if (rd_vld == '0) next_state = CHECK;
      CHECK:            next_state = (rd_sum == wr_sum) ? DONE : FAIL;
      default:          next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_lat   <= '0;
      pc_lat     <= '0;
      cnt_lat    <= '0;
      verify_lat <= 1'b0;
      idx        <= '0;
      rd_idx     <= '0;
      wr_sum     <= '0;
      rd_sum     <= '0;
      rd_vld     <= '0;
      sram_en    <= 1'b0;
      sram_sel   <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      pc_init    <= '0;
    end else begin
      sram_en  <= 1'b0;
      sram_sel <= 1'b0;
      sram_we  <= 1'b0;
      // Tracks each outstanding read so its data is summed exactly RD_LAT cycles later.
      rd_vld   <= (rd_vld << 1) | RD_LAT'(sram_en & ~sram_we);

      if (start_ok) begin
        base_lat   <= base_addr;
        pc_lat     <= pc_start;
        cnt_lat    <= word_count;
        verify_lat <= verify_en;
        idx        <= '0;
        rd_idx     <= '0;
        wr_sum     <= '0;
        rd_sum     <= '0;
      end

      if (accept) begin
        sram_en    <= 1'b1;
        sram_sel   <= 1'b1;
        sram_we    <= 1'b1;
        sram_addr  <= base_lat + ADDR_WIDTH'(idx);
        sram_wdata <= in_data;
        idx        <= idx + 1'b1;
        wr_sum     <= wr_sum + in_data;
      end

      if (state == VFY_RD && rd_idx != cnt_lat) begin
        sram_en   <= 1'b1;
        sram_sel  <= 1'b1;
        sram_addr <= base_lat + ADDR_WIDTH'(rd_idx);
        rd_idx    <= rd_idx + 1'b1;
      end

      if (rd_vld[RD_LAT-1]) rd_sum <= rd_sum + sram_rdata;

      // A zero-length load reaches DONE straight from start, before pc_lat is valid.
      if (next_state == DONE) pc_init <= start_ok ? pc_start : pc_lat;
    end
  end

endmodule
